// File: rtl/gps_srq_sched.sv
// rtl/gps_srq_sched.sv - GPS channel service-request scheduler with round-robin and host guard
// Optional per-channel overrun counters are built when GPS_SRQ_OVR_EN is defined.
module gps_srq_sched #(
  parameter int NCHANS     = 12,
  parameter int HOST_GUARD = 4,
  parameter int OVR_BITS   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NCHANS-1:0]   chan_srq,
  input  logic                host_srq,
  input  logic                mask_wr,
  input  logic [NCHANS-1:0]   mask_din,
  input  logic                ack,
  output logic                grant_valid,
  output logic                grant_host,
  output logic [3:0]          grant_chan,
  output logic [NCHANS:0]     pending,
  input  logic [3:0]          ovr_sel,
  input  logic                ovr_clr,
  output logic [OVR_BITS-1:0] ovr_count
);
  typedef enum logic [1:0] {IDLE, ARB, GRANT} state_t;

  localparam logic [3:0] LAST  = 4'(NCHANS - 1);
  localparam logic [3:0] GUARD = 4'(HOST_GUARD);
  localparam logic [4:0] NC5   = 5'(NCHANS);

  state_t                state;
  logic [NCHANS-1:0]     pend, mask, set_v, ack_clr, mask_clr, pend_n;
  logic [2*NCHANS-1:0]   rot;
  logic [3:0]            rr, gcnt, scan_idx;
  logic [4:0]            scan_off, scan_sum;
  logic                  host_q, scan_hit, ack_chan;

  assign ack_chan = ack && (state == GRANT) && !grant_host;
  assign set_v    = chan_srq & mask;
  assign mask_clr = mask_wr ? ~mask_din : '0;

  always_comb begin
    ack_clr = '0;
    for (int i = 0; i < NCHANS; i++)
      ack_clr[i] = ack_chan && (grant_chan == 4'(i));
  end

  // A new pulse beats the ack clear; disabling a channel beats everything.
  assign pend_n = ((pend & ~ack_clr) | set_v) & ~mask_clr;

  // Rotate so bit 0 is the channel at rr, then take the lowest set offset.
  assign rot = {pend, pend} >> rr;

  always_comb begin
    scan_hit = 1'b0;
    scan_off = '0;
    for (int j = NCHANS - 1; j >= 0; j--) begin
      if (rot[j]) begin
        scan_hit = 1'b1;
        scan_off = 5'(j);
      end
    end
  end

  assign scan_sum = {1'b0, rr} + scan_off;
  assign scan_idx = (scan_sum >= NC5) ? 4'(scan_sum - NC5) : scan_sum[3:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pend        <= '0;
      mask        <= '0;
      rr          <= '0;
      gcnt        <= '0;
      host_q      <= 1'b0;
      grant_valid <= 1'b0;
      grant_host  <= 1'b0;
      grant_chan  <= '0;
    end else begin
      pend   <= pend_n;
      host_q <= host_srq;
      if (mask_wr)
        mask <= mask_din;
      case (state)
        IDLE: begin
          if ((|pend) || host_srq)
            state <= ARB;
        end
        ARB: begin
          if (host_srq && ((gcnt >= GUARD) || !(|pend))) begin
            state       <= GRANT;
            grant_valid <= 1'b1;
            grant_host  <= 1'b1;
          end else if (scan_hit) begin
            state       <= GRANT;
            grant_valid <= 1'b1;
            grant_host  <= 1'b0;
            grant_chan  <= scan_idx;
          end else begin
            state <= IDLE;
          end
        end
        GRANT: begin
          if (ack) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
            grant_host  <= 1'b0;
            if (grant_host) begin
              gcnt <= '0;
            end else begin
              rr   <= (grant_chan == LAST) ? 4'd0 : grant_chan + 4'd1;
              gcnt <= !host_srq ? 4'd0 : ((gcnt == 4'hF) ? gcnt : gcnt + 4'd1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign pending = {host_q, pend};

`ifdef GPS_SRQ_OVR_EN
  logic [OVR_BITS-1:0] ovr [NCHANS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCHANS; i++)
        ovr[i] <= '0;
    end else begin
      for (int i = 0; i < NCHANS; i++) begin
        if (ovr_clr && (ovr_sel == 4'(i)))
          ovr[i] <= '0;
        else if (set_v[i] && pend[i] && !ack_clr[i] && !mask_clr[i] && (ovr[i] != '1))
          ovr[i] <= ovr[i] + OVR_BITS'(1);
      end
    end
  end

  always_comb begin
    ovr_count = '0;
    for (int i = 0; i < NCHANS; i++)
      if (ovr_sel == 4'(i))
        ovr_count = ovr[i];
  end
`else
  logic unused_ovr;
  assign unused_ovr = ^{ovr_sel, ovr_clr};
  assign ovr_count  = '0;
`endif

endmodule

// File: doc/gps_srq_sched.md
# gps_srq_sched

Service-request scheduler for the GPS channel array. Captures per-channel epoch pulses and the host request into pending flags and selects one requester at a time with round-robin fairness and a host starvation guard. Holds the grant until the embedded CPU acknowledges it. Sits between the demodulator epoch outputs and the CPU command decoder, replacing the flat priority SRQ readout.

## Interface

Parameters:
- NCHANS, 12: number of GPS channels; legal range 1..16.
- HOST_GUARD, 4: maximum consecutive channel grants issued while host_srq is high before the host is forced in; legal range 1..15.
- OVR_BITS, 4: width of each per-channel overrun counter.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- chan_srq  in  NCHANS  per-channel epoch pulses, one cycle wide.
- host_srq  in  1  host request, level-sensitive.
- mask_wr  in  1  write strobe for the channel enable mask.
- mask_din  in  NCHANS  new mask value; 1 = channel enabled.
- ack  in  1  CPU acknowledge of the current grant.
- grant_valid  out  1  a grant is outstanding.
- grant_host  out  1  the outstanding grant is the host request.
- grant_chan  out  4  granted channel index; valid only when grant_valid=1 and grant_host=0.
- pending  out  NCHANS+1  {host_srq, channel pending flags}, for snapshot readout.
- ovr_sel  in  4  channel index for overrun readout.
- ovr_clr  in  1  clears the counter addressed by ovr_sel.
- ovr_count  out  OVR_BITS  overrun count of channel ovr_sel; combinational read.

## Operation

- Pending flag:
  - pend[i] is set on chan_srq[i] & mask[i].
  - It is cleared by ack while the grant is channel i and not host.
  - If set and clear occur in the same cycle, set wins.
- Mask:
  - On mask_wr, mask <= mask_din.
  - Any pend bit whose mask bit goes 0 is cleared in the same cycle.
  - An outstanding grant is not revoked; a later ack still completes it normally.
- Overrun: chan_srq[i] & mask[i] while pend[i]=1, and not cleared in that cycle, increments ovr[i]. The counter saturates at all-ones.
- Arbitration state: round-robin pointer rr (4 bits) and guard counter gcnt (4 bits).
- FSM states IDLE, ARB and GRANT:
  - IDLE -> ARB when (|pend) | host_srq.
  - ARB selects the requester and registers the choice, then -> GRANT, where grant_valid=1.
  - Selection order in ARB:
    - Host is chosen if host_srq & (gcnt >= HOST_GUARD or pend==0).
    - Otherwise the first set pend index scanning up from rr, wrapping at NCHANS-1 -> 0.
    - If nothing remains set (it was masked away), ARB returns to IDLE with no grant.
  - GRANT -> IDLE on ack. ack outside GRANT is ignored.
- Updates on ack of a channel grant:
  - rr <= grant_chan+1, wrapping to 0 after NCHANS-1.
  - gcnt <= gcnt+1 (saturating) if host_srq is high, else 0.
- Updates on ack of a host grant:
  - gcnt <= 0.
  - No flag is cleared; the host must drop host_srq itself.
- Reset values: grant_valid=0, grant_host=0, grant_chan=0, pend=0, mask=0, rr=0, gcnt=0, ovr=0, state=IDLE.

## Timing

- A pulse sampled at edge N sets pend after N. The FSM is in ARB after N+1, and grant_valid=1 after N+2.
- Minimum grant-to-grant spacing is 3 cycles: ack at edge M gives IDLE after M, ARB after M+1, grant_valid after M+2.
- grant_valid, grant_host and grant_chan are registered and stable throughout GRANT.
- pending is registered and reflects flags one cycle after the event.
- rst_n low asynchronously forces every register to its reset value mid-grant. There is no ack-less recovery other than reset.

## Configuration

- GPS_SRQ_OVR_EN defined: overrun counters, ovr_clr and ovr_count are implemented as described.
- GPS_SRQ_OVR_EN undefined:
  - No counters are built.
  - ovr_count is tied to 0.
  - ovr_sel and ovr_clr are ignored.
  - Scheduling behaviour is identical.

## Test plan

- Single epoch: mask=0x001, pulse chan 0 at cycle 10 -> grant_valid=1, grant_chan=0 after cycle 12. Ack -> pend[0]=0, rr=1.
- Round-robin: mask=0xFFF, pulses on chans 2, 5 and 11 simultaneously, rr=0. Acks issued immediately -> grants in order 2, 5, 11, each 3 cycles apart.
- Host guard: HOST_GUARD=4, host_srq held high, all 12 channels pulsed repeatedly -> host granted after every 4 channel grants, and gcnt returns to 0.
- Overrun: with GPS_SRQ_OVR_EN defined, chan 3 pulsed 20 times without ack -> ovr_count=15 at ovr_sel=3. ovr_clr -> 0. With the macro undefined -> ovr_count=0.
- Set/clear collision: ack of chan 7 in the same cycle as a new chan 7 pulse -> pend[7] stays 1, ovr unchanged, and chan 7 is granted again.
- Mask and reset:
  - Clear mask bit 4 while grant_chan=4 is outstanding -> grant holds until ack, and pend[4]=0.
  - rst_n pulsed low mid-GRANT -> all outputs 0 immediately.
